alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 173 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a 4-bit ALU, sequenced IDLE->GRANT->EXEC->DONE.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module alu_arbiter (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [2:0] op0,
   input  logic [2:0] op1,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [3:0] result,
   output logic       c,
   output logic       z,
   output logic       busy
);

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StExec,
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic       winner_q, winner_d;
   logic [2:0] op_q, op_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [3:0] result_q, result_d;
   logic       c_q, c_d;
   logic       z_q, z_d;

   logic       pick;
   logic [4:0] sum;
   logic [3:0] alu_res;
   logic       alu_c;

`ifdef ALU_ARB_RR_EN
   logic last_q, last_d;

   // On a tie the requester not served last wins.
   always_comb begin
      pick   = req1 & ~req0;
      if (req0 && req1) begin
         pick = ~last_q;
      end
      last_d = last_q;
      if (state_q == StIdle && (req0 || req1)) begin
         last_d = pick;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      pick = req1 & ~req0;
   end
`endif

   always_comb begin
      sum     = 5'b0;
      alu_res = 4'b0;
      alu_c   = 1'b0;
      case (op_q)
         3'b000:  alu_res = ~a_q;
         3'b001:  alu_res = a_q & b_q;
         3'b010:  alu_res = a_q | b_q;
         3'b011:  alu_res = a_q ^ b_q;
         3'b100:  alu_res = ~(a_q ^ b_q);
         3'b101: begin
            sum     = {1'b0, a_q} + {1'b0, b_q};
            alu_res = sum[3:0];
            alu_c   = sum[4];
         end
         3'b110: begin
            // Carry out of a + ~b + 1 is the unsigned no-borrow flag.
            sum     = {1'b0, a_q} + {1'b0, ~b_q} + 5'd1;
            alu_res = sum[3:0];
            alu_c   = sum[4];
         end
         default: begin
            sum     = {1'b0, a_q} + 5'd1;
            alu_res = sum[3:0];
            alu_c   = sum[4];
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      c_d      = c_q;
      z_d      = z_q;
      case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               state_d  = StGrant;
               winner_d = pick;
            end
         end
         StGrant: begin
            op_d    = winner_q ? op1 : op0;
            a_d     = winner_q ? a1 : a0;
            b_d     = winner_q ? b1 : b0;
            state_d = StExec;
         end
         StExec: begin
            result_d = alu_res;
            c_d      = alu_c;
            z_d      = (alu_res == 4'b0000);
            state_d  = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         winner_q <= 1'b0;
         op_q     <= 3'b0;
         a_q      <= 4'b0;
         b_q      <= 4'b0;
         result_q <= 4'b0;
         c_q      <= 1'b0;
         z_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         c_q      <= c_d;
         z_q      <= z_d;
      end
   end

   // Outputs decode only registered state so reset clears them without waiting for a clock.
   always_comb begin
      gnt0   = (state_q == StGrant) && !winner_q;
      gnt1   = (state_q == StGrant) && winner_q;
      done0  = (state_q == StDone) && !winner_q;
      done1  = (state_q == StDone) && winner_q;
      busy   = (state_q != StIdle);
      result = result_q;
      c      = c_q;
      z      = z_q;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table through a scoreboard queue, plus
// reset, abort and tie-break sequences.
module tb_alu_arbiter;

   logic       clk;
   logic       reset_n;
   logic       req0, req1;
   logic [2:0] op0, op1;
   logic [3:0] a0, b0, a1, b1;
   logic       gnt0, gnt1, done0, done1;
   logic [3:0] result;
   logic       c, z, busy;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       who;
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] res;
      logic       c;
      logic       z;
   } vec_t;

   localparam int NumVec = 13;
   vec_t vecs [NumVec];
   vec_t sb [$];

   alu_arbiter dut (
      .clk    (clk),
      .reset_n(reset_n),
      .req0   (req0),
      .req1   (req1),
      .op0    (op0),
      .op1    (op1),
      .a0     (a0),
      .b0     (b0),
      .a1     (a1),
      .b1     (b1),
      .gnt0   (gnt0),
      .gnt1   (gnt1),
      .done0  (done0),
      .done1  (done1),
      .result (result),
      .c      (c),
      .z      (z),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Grants and dones must be mutually exclusive at all times.
   always @(negedge clk) begin
      if (reset_n) begin
         check("gnt_exclusive", int'(gnt0 & gnt1), 0);
         check("done_exclusive", int'(done0 & done1), 0);
      end
   end

   task automatic run_vec(input int i, input bit drop_early);
      vec_t v;
      vec_t e;
      int   cyc;
      v = vecs[i];
      @(negedge clk);
      if (v.who) begin
         req1 = 1'b1; op1 = v.op; a1 = v.a; b1 = v.b;
      end else begin
         req0 = 1'b1; op0 = v.op; a0 = v.a; b0 = v.b;
      end
      sb.push_back(v);
      @(negedge clk);
      check("gnt_winner", int'(v.who ? gnt1 : gnt0), 1);
      check("gnt_loser", int'(v.who ? gnt0 : gnt1), 0);
      @(negedge clk);
      op0 = ~op0; a0 = ~a0; b0 = ~b0;
      op1 = ~op1; a1 = ~a1; b1 = ~b1;
      if (drop_early) begin
         req0 = 1'b0; req1 = 1'b0;
      end
      check("exec_busy", int'(busy), 1);
      check("exec_no_gnt_done", int'(gnt0 | gnt1 | done0 | done1), 0);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(done0 || done1) && cyc < 6);
      check("done_latency", cyc, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("done_requester", int'(e.who ? done1 : done0), 1);
         check("result", int'(result), int'(e.res));
         check("carry", int'(c), int'(e.c));
         check("zero", int'(z), int'(e.z));
         req0 = 1'b0; req1 = 1'b0;
         @(negedge clk);
         check("idle_busy", int'(busy), 0);
         check("done_one_cycle", int'(done0 | done1), 0);
         check("result_hold", int'(result), int'(e.res));
      end
   endtask

   task automatic check_all_zero(input string name);
      check(name, int'({gnt0, gnt1, done0, done1, result, c, z, busy}), 0);
   endtask

   initial begin
      int   served [$];
      int   done_t [$];
      int   exp_order [4];
      int   cyc;
      int   dones;

      vecs[0]  = '{1'b0, 3'b101, 4'b0111, 4'b1001, 4'b0000, 1'b1, 1'b1};
      vecs[1]  = '{1'b1, 3'b110, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 3'b100, 4'b1010, 4'b0110, 4'b0011, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 3'b000, 4'b1010, 4'b0000, 4'b0101, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 3'b001, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 3'b010, 4'b1100, 4'b0011, 4'b1111, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 3'b011, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 3'b111, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 3'b111, 4'b0110, 4'b1111, 4'b0111, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 3'b110, 4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 3'b101, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 3'b110, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 3'b100, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0};

      reset_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      op0 = 3'b0; op1 = 3'b0;
      a0 = 4'b0; b0 = 4'b0; a1 = 4'b0; b1 = 4'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset_state");
      reset_n = 1'b1;

      for (int i = 0; i < NumVec; i++) begin
         run_vec(i, (i % 3) == 2);
      end

      // Reset asserted while a grant is showing.
      @(negedge clk);
      req0 = 1'b1; op0 = 3'b101; a0 = 4'b0011; b0 = 4'b0100;
      @(negedge clk);
      check("pre_reset_gnt", int'(gnt0), 1);
      reset_n = 1'b0;
      #1;
      check_all_zero("reset_midstream");
      req0 = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("after_reset_idle", int'(busy), 0);

      run_vec(2, 1'b0);

      // Abort during EXEC: no done, result cleared, next request served normally.
      @(negedge clk);
      req1 = 1'b1; op1 = 3'b101; a1 = 4'b0001; b1 = 4'b0010;
      @(negedge clk);
      check("abort_gnt", int'(gnt1), 1);
      @(negedge clk);
      check("abort_in_exec", int'(busy), 1);
      reset_n = 1'b0;
      #1;
      check_all_zero("abort_outputs");
      req1 = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      dones = 0;
      repeat (5) begin
         @(negedge clk);
         if (done0 || done1) dones++;
      end
      check("abort_no_done", dones, 0);
      check("abort_result", int'(result), 0);
      run_vec(11, 1'b0);

      // Tie held from reset.
`ifdef ALU_ARB_RR_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      @(negedge clk);
      reset_n = 1'b0;
      req0 = 1'b1; op0 = 3'b101; a0 = 4'b0001; b0 = 4'b0001;
      req1 = 1'b1; op1 = 3'b111; a1 = 4'b0000; b1 = 4'b0000;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("first_req_after_reset", int'(gnt0 | gnt1), 1);
      cyc = 1;
      while (served.size() < 4 && cyc < 40) begin
         if (done0 || done1) begin
            served.push_back(done1 ? 1 : 0);
            done_t.push_back(cyc);
            check("tie_result", int'(result), done1 ? 1 : 2);
         end
         @(negedge clk);
         cyc++;
      end
      check("tie_count", served.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < served.size()) check("tie_order", served[k], exp_order[k]);
         if (k > 0 && k < done_t.size()) check("tie_spacing", done_t[k] - done_t[k-1], 4);
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (6) @(negedge clk);
      check("final_idle", int'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
